// File: rtl/i2c_control.sv
// Register read/write sequencer for i2c_bit_shift: expands one host request into
// START/WR/RD/NACK/STOP primitives, one per Go/Trans_Done handshake.
module i2c_control #(
  parameter bit ABORT_ON_NACK = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wrreg_req,
  input  logic        rdreg_req,
  input  logic [6:0]  device_id,
  input  logic [15:0] addr,
  input  logic        addr_mode,
  input  logic [7:0]  wrdata,
  output logic [7:0]  rddata,
  output logic        RW_Done,
  output logic        ack_err,
  output logic        busy,
  output logic [5:0]  Cmd,
  output logic        Go,
  output logic [7:0]  Tx_DATA,
  input  logic        Trans_Done,
  input  logic        ack_o,
  input  logic [7:0]  Rx_DATA
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_STA1 = 4'd1;
  localparam logic [3:0] S_DEVW = 4'd2;
  localparam logic [3:0] S_REGH = 4'd3;
  localparam logic [3:0] S_REGL = 4'd4;
  localparam logic [3:0] S_WDAT = 4'd5;
  localparam logic [3:0] S_STA2 = 4'd6;
  localparam logic [3:0] S_DEVR = 4'd7;
  localparam logic [3:0] S_RDAT = 4'd8;
  localparam logic [3:0] S_NACK = 4'd9;
  localparam logic [3:0] S_STOP = 4'd10;
  localparam logic [3:0] S_DONE = 4'd11;

  localparam logic [5:0] C_WR   = 6'b000001;
  localparam logic [5:0] C_STA  = 6'b000010;
  localparam logic [5:0] C_RD   = 6'b000100;
  localparam logic [5:0] C_STO  = 6'b001000;
  localparam logic [5:0] C_NACK = 6'b100000;

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic [6:0]  dev_q;
  logic [15:0] addr_q;
  logic        mode_q;
  logic [7:0]  wdat_q;
  logic        read_q;
  logic        nack_flag;
  logic        wr_step;
  logic        nack_now;
  logic        abort_now;
  logic [5:0]  next_cmd;
  logic [7:0]  next_tx;

  // Successor of the current command state once its Trans_Done arrives
  always_comb begin
    wr_step   = (state == S_DEVW) || (state == S_REGH) || (state == S_REGL) ||
                (state == S_WDAT) || (state == S_DEVR);
    nack_now  = wr_step && ack_o;
    abort_now = nack_now && ABORT_ON_NACK;
    next_state = S_IDLE;
    case (state)
      S_STA1:  next_state = S_DEVW;
      S_DEVW:  next_state = abort_now ? S_STOP : (mode_q ? S_REGH : S_REGL);
      S_REGH:  next_state = abort_now ? S_STOP : S_REGL;
      S_REGL:  next_state = abort_now ? S_STOP : (read_q ? S_STA2 : S_WDAT);
      S_WDAT:  next_state = S_STOP;
      S_STA2:  next_state = S_DEVR;
      S_DEVR:  next_state = abort_now ? S_STOP : S_RDAT;
      S_RDAT:  next_state = S_NACK;
      S_NACK:  next_state = S_STOP;
      S_STOP:  next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // Primitive and payload for the state about to be entered; non-WR steps keep Tx_DATA
  always_comb begin
    next_cmd = Cmd;
    next_tx  = Tx_DATA;
    case (next_state)
      S_STA1, S_STA2: next_cmd = C_STA;
      S_DEVW: begin next_cmd = C_WR; next_tx = {dev_q, 1'b0}; end
      S_REGH: begin next_cmd = C_WR; next_tx = addr_q[15:8]; end
      S_REGL: begin next_cmd = C_WR; next_tx = addr_q[7:0]; end
      S_WDAT: begin next_cmd = C_WR; next_tx = wdat_q; end
      S_DEVR: begin next_cmd = C_WR; next_tx = {dev_q, 1'b1}; end
      S_RDAT: next_cmd = C_RD;
      S_NACK: next_cmd = C_NACK;
      S_STOP: next_cmd = C_STO;
      default: begin next_cmd = Cmd; next_tx = Tx_DATA; end
    endcase
  end

  // Sequencer state, request latch and registered handshake outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      dev_q     <= 7'd0;
      addr_q    <= 16'd0;
      mode_q    <= 1'b0;
      wdat_q    <= 8'd0;
      read_q    <= 1'b0;
      nack_flag <= 1'b0;
      rddata    <= 8'd0;
      RW_Done   <= 1'b0;
      ack_err   <= 1'b0;
      busy      <= 1'b0;
      Cmd       <= 6'd0;
      Go        <= 1'b0;
      Tx_DATA   <= 8'd0;
    end else begin
      Go      <= 1'b0;
      RW_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wrreg_req || rdreg_req) begin
            dev_q     <= device_id;
            addr_q    <= addr;
            mode_q    <= addr_mode;
            wdat_q    <= wrdata;
            read_q    <= !wrreg_req;
            nack_flag <= 1'b0;
            busy      <= 1'b1;
            state     <= S_STA1;
            Go        <= 1'b1;
            Cmd       <= C_STA;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_STA1, S_DEVW, S_REGH, S_REGL, S_WDAT, S_STA2,
        S_DEVR, S_RDAT, S_NACK, S_STOP: begin
          if (Trans_Done) begin
            if (nack_now) nack_flag <= 1'b1;
            if (state == S_RDAT) rddata <= Rx_DATA;
            state <= next_state;
            if (next_state == S_DONE) begin
              RW_Done <= 1'b1;
              ack_err <= nack_flag;
            end else begin
              Go      <= 1'b1;
              Cmd     <= next_cmd;
              Tx_DATA <= next_tx;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_control.sv
// Directed + randomized bench for i2c_control: a bit-shifter responder, a
// transaction-level reference model and a handshake checker.
module tb_i2c_control;

  localparam logic [5:0] T_WR   = 6'b000001;
  localparam logic [5:0] T_STA  = 6'b000010;
  localparam logic [5:0] T_RD   = 6'b000100;
  localparam logic [5:0] T_STO  = 6'b001000;
  localparam logic [5:0] T_NACK = 6'b100000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        wrreg_req = 1'b0;
  logic        rdreg_req = 1'b0;
  logic [6:0]  device_id = 7'd0;
  logic [15:0] addr = 16'd0;
  logic        addr_mode = 1'b0;
  logic [7:0]  wrdata = 8'd0;
  logic [7:0]  rddata;
  logic        RW_Done;
  logic        ack_err;
  logic        busy;
  logic [5:0]  Cmd;
  logic        Go;
  logic [7:0]  Tx_DATA;
  logic        Trans_Done = 1'b0;
  logic        ack_o = 1'b0;
  logic [7:0]  Rx_DATA = 8'd0;

  int n_assert = 0;
  int n_fail = 0;
  int nack_step = -1;
  int wr_idx = 0;
  logic [7:0]  rx_byte = 8'd0;
  logic [7:0]  model_rddata = 8'd0;
  logic [13:0] got_q[$];
  logic [13:0] exp_q[$];

  always #5 Clk = ~Clk;

  i2c_control dut (
    .Clk(Clk), .Rst(Rst), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
    .device_id(device_id), .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata),
    .rddata(rddata), .RW_Done(RW_Done), .ack_err(ack_err), .busy(busy),
    .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA), .Trans_Done(Trans_Done),
    .ack_o(ack_o), .Rx_DATA(Rx_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-shifter stand-in: logs each issued primitive and completes it after a random delay
  always begin : responder
    int dly;
    bit aborted;
    @(posedge Clk); #1;
    while (Go && !Rst) begin
      got_q.push_back({Cmd, Tx_DATA});
      dly = $urandom_range(1, 4);
      aborted = 1'b0;
      for (int i = 0; i < dly; i++) begin
        @(posedge Clk); #1;
        if (Rst) aborted = 1'b1;
      end
      if (aborted) break;
      Trans_Done = 1'b1;
      if (Cmd == T_WR) begin
        ack_o = (wr_idx == nack_step);
        wr_idx++;
      end
      if (Cmd == T_RD) Rx_DATA = rx_byte;
      @(posedge Clk); #1;
      Trans_Done = 1'b0;
      ack_o = 1'b0;
    end
  end

  // Handshake checker: no overlapping Go, stable Cmd/Tx_DATA, Go or RW_Done one cycle after Trans_Done
  bit outst = 1'b0;
  bit go_due = 1'b0;
  bit done_due = 1'b0;
  logic [5:0] h_cmd = 6'd0;
  logic [7:0] h_tx = 8'd0;
  always @(negedge Clk) begin
    if (Rst) begin
      outst = 1'b0; go_due = 1'b0; done_due = 1'b0;
    end else begin
      if (go_due) chk("hs_go_after_done", Go, 1);
      if (done_due) chk("hs_rwdone_after_stop", RW_Done, 1);
      go_due = 1'b0; done_due = 1'b0;
      if (Go) begin
        chk("hs_go_while_outstanding", outst, 0);
        outst = 1'b1; h_cmd = Cmd; h_tx = Tx_DATA;
      end else if (outst) begin
        chk("hs_cmd_stable", Cmd, h_cmd);
        chk("hs_tx_stable", Tx_DATA, h_tx);
      end
      if (Trans_Done && outst) begin
        outst = 1'b0;
        if (h_cmd == T_STO) done_due = 1'b1; else go_due = 1'b1;
      end
    end
  end

  // Reference: full primitive list for the request, cut short to STOP after a NACKed WR
  task automatic build_expected(input bit is_wr, input logic [6:0] dev, input logic [15:0] a,
                                input bit mode, input logic [7:0] wd, input int nack,
                                output bit e_err);
    logic [13:0] plan[$];
    int widx;
    plan.push_back({T_STA, 8'h00});
    plan.push_back({T_WR, dev, 1'b0});
    if (mode) plan.push_back({T_WR, a[15:8]});
    plan.push_back({T_WR, a[7:0]});
    if (is_wr) begin
      plan.push_back({T_WR, wd});
    end else begin
      plan.push_back({T_STA, 8'h00});
      plan.push_back({T_WR, dev, 1'b1});
      plan.push_back({T_RD, 8'h00});
      plan.push_back({T_NACK, 8'h00});
    end
    plan.push_back({T_STO, 8'h00});
    exp_q.delete();
    e_err = 1'b0;
    widx = 0;
    foreach (plan[i]) begin
      exp_q.push_back(plan[i]);
      if (plan[i][13:8] == T_WR) begin
        if (widx == nack) begin
          e_err = 1'b1;
          exp_q.push_back({T_STO, 8'h00});
          break;
        end
        widx++;
      end
    end
  endtask

  task automatic run_txn(input bit do_wr, input bit do_rd, input logic [6:0] dev,
                         input logic [15:0] a, input bit mode, input logic [7:0] wd,
                         input int nack, input logic [7:0] rx, input bit poke_rd,
                         input string tag);
    bit e_err;
    int seen;
    int t;
    int n;
    logic [7:0] e_rd;
    build_expected(do_wr, dev, a, mode, wd, nack, e_err);
    e_rd = (!do_wr && !e_err) ? rx : model_rddata;
    got_q.delete();
    wr_idx = 0; nack_step = nack; rx_byte = rx;
    @(negedge Clk);
    device_id = dev; addr = a; addr_mode = mode; wrdata = wd;
    wrreg_req = do_wr; rdreg_req = do_rd;
    @(negedge Clk);
    wrreg_req = 1'b0; rdreg_req = 1'b0;
    device_id = 7'($urandom); addr = 16'($urandom); addr_mode = 1'($urandom); wrdata = 8'($urandom);
    chk({tag, "_busy"}, busy, 1);
    seen = 0; t = 0;
    while (seen == 0 && t < 500) begin
      @(negedge Clk);
      t++;
      rdreg_req = (poke_rd && t == 6);
      if (RW_Done) begin
        seen = 1;
        chk({tag, "_ack_err"}, ack_err, e_err);
        chk({tag, "_rddata"}, rddata, e_rd);
      end
    end
    rdreg_req = 1'b0;
    chk({tag, "_rwdone_seen"}, seen, 1);
    @(negedge Clk);
    chk({tag, "_busy_low"}, busy, 0);
    repeat (8) begin
      if (RW_Done) seen++;
      @(negedge Clk);
    end
    chk({tag, "_one_rwdone"}, seen, 1);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cmd"}, got_q[i][13:8], exp_q[i][13:8]);
      if (exp_q[i][13:8] == T_WR) chk({tag, "_tx"}, got_q[i][7:0], exp_q[i][7:0]);
    end
    model_rddata = e_rd;
  endtask

  initial begin
    int t;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_rddata", rddata, 0);
    chk("rst_rw_done", RW_Done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", Cmd, 0);
    chk("rst_go", Go, 0);
    chk("rst_tx", Tx_DATA, 0);
    Rst = 1'b0;

    run_txn(1'b1, 1'b0, 7'h50, 16'h0012, 1'b0, 8'hA5, -1, 8'h00, 1'b0, "wr8");
    run_txn(1'b0, 1'b1, 7'h50, 16'h1234, 1'b1, 8'h00, -1, 8'h3C, 1'b0, "rd16");
    run_txn(1'b0, 1'b1, 7'h50, 16'h0044, 1'b0, 8'h00, 0, 8'h77, 1'b0, "abort_devw");
    run_txn(1'b1, 1'b1, 7'h33, 16'h0101, 1'b0, 8'h5A, -1, 8'h99, 1'b0, "both_req");
    run_txn(1'b1, 1'b0, 7'h21, 16'hA0B1, 1'b1, 8'hC3, -1, 8'h00, 1'b1, "poke_rd");

    // Reset while the REGL step is outstanding
    got_q.delete(); wr_idx = 0; nack_step = -1; rx_byte = 8'h11;
    @(negedge Clk);
    device_id = 7'h2A; addr = 16'hBEEF; addr_mode = 1'b1; rdreg_req = 1'b1;
    @(negedge Clk);
    rdreg_req = 1'b0;
    t = 0;
    while (got_q.size() < 4 && t < 500) begin
      @(negedge Clk);
      t++;
    end
    chk("rst_mid_reached_regl", got_q.size(), 4);
    if (got_q.size() >= 4) chk("rst_mid_regl_tx", got_q[3][7:0], 8'hEF);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_go", Go, 0);
    chk("rst_mid_cmd", Cmd, 0);
    chk("rst_mid_tx", Tx_DATA, 0);
    chk("rst_mid_rddata", rddata, 0);
    chk("rst_mid_rw_done", RW_Done, 0);
    chk("rst_mid_ack_err", ack_err, 0);
    @(negedge Clk);
    Rst = 1'b0;
    model_rddata = 8'h00;
    run_txn(1'b1, 1'b0, 7'h50, 16'h0034, 1'b0, 8'h5E, -1, 8'h00, 1'b0, "after_rst");

    for (int k = 0; k < 20; k++) begin
      bit w;
      int nk;
      w  = 1'($urandom);
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_txn(w, !w, 7'($urandom), 16'($urandom), 1'($urandom), 8'($urandom),
              nk, 8'($urandom), 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
